tqvp_nkanderson_wdt_ctrl: RTL and testbench

//  Watchdog sequencing controller behind the TinyQV WDT peripheral register file.
//  - Owns the countdown counter and the IDLE/RUN/WARN/BITE state machine.
//  - Accepts start, stop, feed and lock commands decoded from bus writes.
//  - Drives the early-warning interrupt and the timeout reset pulse.

---
 rtl/tqvp_nkanderson_wdt_pkg.sv | 18 +
 rtl/tqvp_nkanderson_wdt_counter.sv | 30 +++
 rtl/tqvp_nkanderson_wdt_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tqvp_nkanderson_wdt_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_nkanderson_wdt_pkg.sv
// Shared types and default constants for the TinyQV watchdog controller.
package tqvp_nkanderson_wdt_pkg;

  // Watchdog sequencing states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WARN = 2'd2,
    ST_BITE = 2'd3
  } wdt_state_t;

  // The only feed key that reloads the counter.
  localparam logic [31:0] DEFAULT_FEED_KEY = 32'h5A5A_A5A5;

  // Number of cycles the timeout reset pulse stays asserted.
  localparam int DEFAULT_BITE_LEN = 16;

endpackage

// File: rtl/tqvp_nkanderson_wdt_counter.sv
// Generic down-counter with load, decrement and zero flag.
// Used both for the watchdog countdown and for timing the bite pulse.
module tqvp_nkanderson_wdt_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  import tqvp_nkanderson_wdt_pkg::*;

  assign zero = (count == '0);

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/tqvp_nkanderson_wdt_ctrl.sv
// Watchdog sequencing controller: IDLE/RUN/WARN/BITE state machine,
// countdown, sticky lock / warning / bad-key flags and the bite pulse.
import tqvp_nkanderson_wdt_pkg::*;

module tqvp_nkanderson_wdt_ctrl #(
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] FEED_KEY = CNT_W'(DEFAULT_FEED_KEY),
  parameter int               BITE_LEN = DEFAULT_BITE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             lock_set,
  input  logic             feed_valid,
  input  logic [CNT_W-1:0] feed_key,
  input  logic             int_clr,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_warn,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             locked,
  output logic             warn_irq,
  output logic             bad_key,
  output logic             wdt_bite
);

  wdt_state_t       cur_st, nxt_st;
  logic             locked_d, warn_d, bad_d, bite_d;
  logic             warn_set, bad_set, clr_ok;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_q, cnt_dec_val;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_count_unused;
  logic             enter_bite;
  logic [CNT_W-1:0] timeout_eff;
  logic             lock_eff, stop_eff, feed_ok, feed_bad;

  // A zero timeout would expire immediately, so it behaves as one cycle.
  assign timeout_eff = (cfg_timeout == '0) ? CNT_W'(1) : cfg_timeout;
  assign cnt_dec_val = cnt_q - CNT_W'(1);

  // A lock requested in the same cycle already blocks a stop or wrong-key feed.
  assign lock_eff = locked | lock_set;
  assign stop_eff = stop & ~lock_eff;
  assign feed_ok  = feed_valid & (feed_key == FEED_KEY);
  assign feed_bad = feed_valid & ~feed_ok;

  tqvp_nkanderson_wdt_counter #(.W(CNT_W)) u_count (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_q),
    .zero     (cnt_zero)
  );

  tqvp_nkanderson_wdt_counter #(.W(CNT_W)) u_bite_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CNT_W'(BITE_LEN - 1)),
    .dec      (tmr_dec),
    .count    (tmr_count_unused),
    .zero     (tmr_zero)
  );

  // Next-state, counter control and flag set/clear decisions.
  always_comb begin
    nxt_st       = cur_st;
    locked_d     = locked;
    warn_set     = 1'b0;
    bad_set      = 1'b0;
    clr_ok       = int_clr;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    enter_bite   = 1'b0;

    case (cur_st)
      ST_IDLE: begin
        locked_d = lock_eff;
        if (start && !stop_eff) begin
          nxt_st       = ST_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = timeout_eff;
        end
      end

      ST_RUN, ST_WARN: begin
        locked_d = lock_eff;
        if (stop_eff) begin
          nxt_st       = ST_IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else if (feed_ok) begin
          nxt_st       = ST_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = timeout_eff;
        end else if (feed_bad && lock_eff) begin
          enter_bite = 1'b1;
        end else begin
          bad_set = feed_bad;
          if (cnt_zero || cnt_dec_val == '0) begin
            enter_bite = 1'b1;
          end else begin
            cnt_dec = 1'b1;
            if (cur_st == ST_RUN && cfg_warn != '0 && cnt_dec_val <= cfg_warn) begin
              nxt_st   = ST_WARN;
              warn_set = 1'b1;
            end
          end
        end
      end

      default: begin
        clr_ok = 1'b0;
        if (tmr_zero) begin
          cnt_load = 1'b1;
          if (locked) begin
            nxt_st       = ST_RUN;
            cnt_load_val = timeout_eff;
          end else begin
            nxt_st       = ST_IDLE;
            cnt_load_val = '0;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
    endcase

    if (enter_bite) begin
      nxt_st       = ST_BITE;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
      tmr_load     = 1'b1;
    end
  end

  // A set in the same cycle as int_clr wins, so no event is lost.
  assign warn_d = warn_set | (warn_irq & ~clr_ok);
  assign bad_d  = bad_set  | (bad_key  & ~clr_ok);
  assign bite_d = (nxt_st == ST_BITE);

  // State and sticky flag registers; reset also drops an active bite.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st   <= ST_IDLE;
      locked   <= 1'b0;
      warn_irq <= 1'b0;
      bad_key  <= 1'b0;
      wdt_bite <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      locked   <= locked_d;
      warn_irq <= warn_d;
      bad_key  <= bad_d;
      wdt_bite <= bite_d;
    end
  end

  assign count = cnt_q;
  assign state = cur_st;

endmodule

// File: tb/tb_tqvp_nkanderson_wdt_ctrl.sv
// Self-checking bench for the watchdog controller: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_tqvp_nkanderson_wdt_ctrl;

  localparam int          CNT_W    = 32;
  localparam logic [31:0] KEY      = 32'h5A5A_A5A5;
  localparam int          BITE_LEN = 16;

  logic        clk = 1'b0;
  logic        rst, start, stop, lock_set, feed_valid, int_clr;
  logic [31:0] feed_key, cfg_timeout, cfg_warn;
  logic [31:0] count;
  logic [1:0]  state;
  logic        locked, warn_irq, bad_key, wdt_bite;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0=idle 1=run 2=warn 3=bite, bite_left = cycles remaining.
  int     m_mode = 0;
  longint m_count = 0;
  int     m_left = 0;
  bit     m_locked = 0, m_warn = 0, m_bad = 0;
  bit     model_on = 0;

  always #5 clk = ~clk;

  tqvp_nkanderson_wdt_ctrl #(
    .CNT_W    (CNT_W),
    .FEED_KEY (KEY),
    .BITE_LEN (BITE_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .lock_set    (lock_set),
    .feed_valid  (feed_valid),
    .feed_key    (feed_key),
    .int_clr     (int_clr),
    .cfg_timeout (cfg_timeout),
    .cfg_warn    (cfg_warn),
    .count       (count),
    .state       (state),
    .locked      (locked),
    .warn_irq    (warn_irq),
    .bad_key     (bad_key),
    .wdt_bite    (wdt_bite)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of the watchdog rules, evaluated on the sampled inputs.
  task automatic modelStep();
    longint tmo;
    bit     lk, set_w, set_b, good;
    model_on = 1;
    tmo   = (cfg_timeout == 0) ? 1 : longint'(cfg_timeout);
    set_w = 0;
    set_b = 0;
    if (rst) begin
      m_mode = 0; m_count = 0; m_left = 0;
      m_locked = 0; m_warn = 0; m_bad = 0;
      return;
    end
    if (m_mode == 3) begin
      m_left--;
      if (m_left == 0) begin
        if (m_locked) begin m_mode = 1; m_count = tmo; end
        else begin m_mode = 0; m_count = 0; end
      end
      return;
    end
    lk = m_locked | lock_set;
    m_locked = lk;
    good = feed_valid && (feed_key == KEY);
    if (m_mode == 0) begin
      if (start && !(stop && !lk)) begin m_mode = 1; m_count = tmo; end
    end else if (stop && !lk) begin
      m_mode = 0; m_count = 0;
    end else if (good) begin
      m_mode = 1; m_count = tmo;
    end else if (feed_valid && lk) begin
      m_mode = 3; m_count = 0; m_left = BITE_LEN;
    end else begin
      if (feed_valid) set_b = 1;
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_mode = 3; m_left = BITE_LEN;
      end else if (m_mode == 1 && cfg_warn != 0 && m_count <= longint'(cfg_warn)) begin
        m_mode = 2; set_w = 1;
      end
    end
    m_warn = set_w | (m_warn & !int_clr);
    m_bad  = set_b | (m_bad & !int_clr);
  endtask

  always @(posedge clk) modelStep();

  // Every cycle, all outputs must agree with the model.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model.count",    64'(count),    64'(m_count));
      checkOutput("model.state",    64'(state),    64'(m_mode));
      checkOutput("model.locked",   64'(locked),   64'(m_locked));
      checkOutput("model.warn_irq", 64'(warn_irq), 64'(m_warn));
      checkOutput("model.bad_key",  64'(bad_key),  64'(m_bad));
      checkOutput("model.wdt_bite", 64'(wdt_bite), 64'(m_mode == 3));
    end
  end

  // Drive one cycle of command pulses, then return them to idle.
  task automatic applyStimulus(input bit st, input bit sp, input bit ls,
                               input bit fv, input logic [31:0] key, input bit ic);
    start = st; stop = sp; lock_set = ls; feed_valid = fv; feed_key = key; int_clr = ic;
    @(negedge clk);
    start = 0; stop = 0; lock_set = 0; feed_valid = 0; feed_key = 0; int_clr = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; lock_set = 0; feed_valid = 0;
    feed_key = 0; int_clr = 0; cfg_timeout = 10; cfg_warn = 0;
    idleCycles(2);
    checkOutput("reset.state", 64'(state), 64'd0);
    checkOutput("reset.count", 64'(count), 64'd0);
    checkOutput("reset.bite",  64'(wdt_bite), 64'd0);
    rst = 0;
    idleCycles(1);

    $display("[TB] plain expiry with timeout 10");
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("expiry.state_run", 64'(state), 64'd1);
    checkOutput("expiry.count10",   64'(count), 64'd10);
    idleCycles(9);
    checkOutput("expiry.count1", 64'(count), 64'd1);
    idleCycles(1);
    checkOutput("expiry.state_bite", 64'(state), 64'd3);
    checkOutput("expiry.bite_rise",  64'(wdt_bite), 64'd1);
    idleCycles(15);
    checkOutput("expiry.bite_last", 64'(wdt_bite), 64'd1);
    idleCycles(1);
    checkOutput("expiry.idle", 64'(state), 64'd0);
    checkOutput("expiry.bite_fall", 64'(wdt_bite), 64'd0);

    $display("[TB] warning, int_clr and good feeds");
    cfg_timeout = 20; cfg_warn = 5;
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(14);
    checkOutput("warn.count6", 64'(count), 64'd6);
    checkOutput("warn.not_yet", 64'(warn_irq), 64'd0);
    idleCycles(1);
    checkOutput("warn.count5", 64'(count), 64'd5);
    checkOutput("warn.irq", 64'(warn_irq), 64'd1);
    checkOutput("warn.state", 64'(state), 64'd2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("warn.cleared", 64'(warn_irq), 64'd0);
    checkOutput("warn.still_warn", 64'(state), 64'd2);
    idleCycles(1);
    checkOutput("feed.count3", 64'(count), 64'd3);
    applyStimulus(0, 0, 0, 1, KEY, 0);
    checkOutput("feed.reload", 64'(count), 64'd20);
    checkOutput("feed.run", 64'(state), 64'd1);
    idleCycles(19);
    checkOutput("feed.count1", 64'(count), 64'd1);
    applyStimulus(0, 0, 0, 1, KEY, 0);
    checkOutput("feed_last.reload", 64'(count), 64'd20);
    checkOutput("feed_last.no_bite", 64'(wdt_bite), 64'd0);
    checkOutput("feed_last.irq_kept", 64'(warn_irq), 64'd1);

    $display("[TB] wrong keys and lock");
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    checkOutput("badkey.flag", 64'(bad_key), 64'd1);
    checkOutput("badkey.count", 64'(count), 64'd19);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("badkey.cleared", 64'(bad_key), 64'd0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("lock.set", 64'(locked), 64'd1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("lock.stop_ignored", 64'(state), 64'd1);
    checkOutput("lock.count16", 64'(count), 64'd16);
    applyStimulus(0, 0, 0, 1, 32'h0, 0);
    checkOutput("lock.bite", 64'(state), 64'd3);
    checkOutput("lock.bite_out", 64'(wdt_bite), 64'd1);
    idleCycles(16);
    checkOutput("lock.rearm_state", 64'(state), 64'd1);
    checkOutput("lock.rearm_count", 64'(count), 64'd20);

    $display("[TB] zero timeout and start/stop collision");
    rst = 1; idleCycles(1); rst = 0;
    checkOutput("rst.unlock", 64'(locked), 64'd0);
    cfg_timeout = 0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("zero.count1", 64'(count), 64'd1);
    idleCycles(1);
    checkOutput("zero.bite", 64'(state), 64'd3);
    idleCycles(16);
    checkOutput("zero.idle", 64'(state), 64'd0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("startstop.idle", 64'(state), 64'd0);

    $display("[TB] reset during bite");
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleCycles(3);
    checkOutput("midbite.active", 64'(wdt_bite), 64'd1);
    rst = 1; idleCycles(1); rst = 0;
    checkOutput("midbite.bite", 64'(wdt_bite), 64'd0);
    checkOutput("midbite.locked", 64'(locked), 64'd0);
    checkOutput("midbite.state", 64'(state), 64'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        cfg_timeout = $urandom_range(0, 40);
        cfg_warn    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
      end
      rst        = ($urandom_range(0, 499) == 0);
      start      = ($urandom_range(0, 9) == 0);
      stop       = ($urandom_range(0, 19) == 0);
      lock_set   = ($urandom_range(0, 199) == 0);
      feed_valid = ($urandom_range(0, 7) == 0);
      feed_key   = ($urandom_range(0, 2) == 0) ? 32'($urandom) : KEY;
      int_clr    = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    rst = 0; start = 0; stop = 0; lock_set = 0; feed_valid = 0; int_clr = 0;
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
